// File: rtl/keypad_scanner_param.sv
// Parametrised matrix-keypad scanner: one-hot active-low column drive,
// 2-FF row synchroniser, press/release debounce, linear key code output.
// Ports: clk, rst_n (async, active low), linhas[ROWS] (rows, active low),
//        colunas[COLS] (columns, active low), tecla[CODE_W] (key code,
//        all-ones = no key), key_valid (press strobe), key_held (key down).
// Optional feature: define KEYPAD_REPEAT_EN for auto-repeat of key_valid.
module keypad_scanner_param #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_TICKS     = 50000,
  parameter int DEBOUNCE_TICKS = 500000,
  parameter int CODE_W         = $clog2(ROWS*COLS+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ROWS-1:0]   linhas,
  output logic [COLS-1:0]   colunas,
  output logic [CODE_W-1:0] tecla,
  output logic              key_valid,
  output logic              key_held
);

  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int SCAN_W = $clog2(SCAN_TICKS);
  localparam int DEB_W  = $clog2(DEBOUNCE_TICKS);
  localparam logic [CODE_W-1:0] NULL_CODE = '1;

  typedef enum logic [1:0] {
    SCAN,
    DEB_PRESS,
    HELD,
    DEB_REL
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [ROWS-1:0]   r_sync1;
  logic [ROWS-1:0]   r_sync2;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic [DEB_W-1:0]  r_deb_cnt;
  logic [CODE_W-1:0] r_tecla;
  logic              r_key_valid;
  logic              r_key_held;

  logic              w_scan_end;
  logic              w_deb_end;
  logic              w_any_low;
  logic              w_row_hi;
  logic [ROW_W-1:0]  w_low_row;
  logic [COL_W-1:0]  w_col_nx;
  logic [CODE_W-1:0] w_code;
  logic              w_hit;
  logic              w_miss;
  logic              w_accept;
  logic              w_done;
  logic              w_deb_inc;
  logic              w_repeat;

  assign w_scan_end = (r_scan_cnt == SCAN_W'(SCAN_TICKS-1));
  assign w_deb_end  = (r_deb_cnt == DEB_W'(DEBOUNCE_TICKS-1));
  assign w_any_low  = ~&r_sync2;
  assign w_row_hi   = r_sync2[r_row];

  assign w_col_nx = (r_col == COL_W'(COLS-1)) ? '0
                  : r_col + 1'b1;

  assign w_code = CODE_W'(r_row) * CODE_W'(COLS)
                + CODE_W'(r_col);

  // Lowest-index low row wins among keys sharing a column.
  always_comb begin
    w_low_row = '0;
    for (int i = ROWS-1; i >= 0; i--) begin
      if (!r_sync2[i]) w_low_row = ROW_W'(i);
    end
  end

  assign w_hit    = (r_state == SCAN) && w_scan_end && w_any_low;
  assign w_miss   = (r_state == SCAN) && w_scan_end && !w_any_low;
  assign w_accept = (r_state == DEB_PRESS) && !w_row_hi && w_deb_end;
  assign w_done   = (r_state == DEB_REL) && w_row_hi && w_deb_end;

  assign w_deb_inc = ((r_state == DEB_PRESS) && !w_row_hi)
                   || ((r_state == DEB_REL) && w_row_hi);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SCAN;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      SCAN: begin
        if (w_hit) w_state_nx = DEB_PRESS;
      end
      DEB_PRESS: begin
        if (w_row_hi)       w_state_nx = SCAN;
        else if (w_deb_end) w_state_nx = HELD;
      end
      HELD: begin
        if (w_row_hi) w_state_nx = DEB_REL;
      end
      DEB_REL: begin
        if (!w_row_hi)      w_state_nx = HELD;
        else if (w_deb_end) w_state_nx = SCAN;
      end
      default: w_state_nx = SCAN;
    endcase
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int REPEAT_TICKS = 8*DEBOUNCE_TICKS;
  localparam int REP_W        = $clog2(REPEAT_TICKS);

  logic [REP_W-1:0] r_rep_cnt;
  logic             w_rep_end;

  assign w_rep_end = (r_rep_cnt == REP_W'(REPEAT_TICKS-1));
  assign w_repeat  = (r_state == HELD) && w_rep_end;

  // Phase is set by the accepted press; counting pauses outside HELD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_cnt <= '0;
    end else if (w_accept) begin
      r_rep_cnt <= '0;
    end else if (r_state == HELD) begin
      r_rep_cnt <= w_rep_end ? '0 : r_rep_cnt + 1'b1;
    end
  end
`else
  assign w_repeat = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= '1;
      r_sync2     <= '1;
      r_col       <= '0;
      r_row       <= '0;
      r_scan_cnt  <= '0;
      r_deb_cnt   <= '0;
      r_tecla     <= NULL_CODE;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_sync1     <= linhas;
      r_sync2     <= r_sync1;
      r_key_valid <= w_accept | w_repeat;

      if ((r_state == SCAN) && !w_scan_end)
        r_scan_cnt <= r_scan_cnt + 1'b1;
      else
        r_scan_cnt <= '0;

      // Any break in stability restarts the debounce window.
      if (w_deb_inc && !w_deb_end)
        r_deb_cnt <= r_deb_cnt + 1'b1;
      else
        r_deb_cnt <= '0;

      if (w_miss || w_done) r_col <= w_col_nx;
      if (w_hit)            r_row <= w_low_row;

      if (w_accept) begin
        r_tecla    <= w_code;
        r_key_held <= 1'b1;
      end else if (w_done) begin
        r_tecla    <= NULL_CODE;
        r_key_held <= 1'b0;
      end
    end
  end

  assign colunas   = ~(COLS'(1) << r_col);
  assign tecla     = r_tecla;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner_param.sv
// Bench for keypad_scanner_param: 4x4 pad model, directed key scenarios,
// expected strobes queued at stimulus time and checked by a monitor.
module tb_keypad_scanner_param;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int CODE_W = $clog2(ROWS*COLS+1);
  localparam logic [CODE_W-1:0] NULLK = '1;

  typedef struct {
    bit                rel;
    logic [CODE_W-1:0] code;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [ROWS-1:0]   linhas;
  logic [COLS-1:0]   colunas;
  logic [CODE_W-1:0] tecla;
  logic              key_valid;
  logic              key_held;

  logic [15:0] keys = '0;
  ev_t         q[$];
  int          vectors = 0;
  int          fails = 0;
  logic        prev_held = 1'b0;

  keypad_scanner_param #(
    .ROWS(ROWS),
    .COLS(COLS),
    .SCAN_TICKS(4),
    .DEBOUNCE_TICKS(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .linhas(linhas),
    .colunas(colunas),
    .tecla(tecla),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its row low while its column is low.
  always_comb begin
    linhas = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[r*COLS+c] && !colunas[c]) linhas[r] = 1'b0;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic push(bit rel, int code);
    ev_t e;
    e.rel  = rel;
    e.code = CODE_W'(code);
    q.push_back(e);
  endtask

  task automatic set_key(int idx, bit v);
    @(posedge clk);
    #1 keys[idx] = v;
  endtask

  task automatic drain(string name, int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    vectors++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d events pending after %0d cycles, want 0",
               name, q.size(), budget);
      q.delete();
    end
  endtask

  // Monitor: every strobe or key-up must match the next queued event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_valid) begin
        if (q.size() == 0) begin
          vectors++;
          fails++;
          $display("FAIL unexpected_pulse: tecla %0h, want no pulse", tecla);
        end else begin
          ev_t e;
          e = q.pop_front();
          chk("pulse_kind", 32'(e.rel), 32'd0);
          chk("pulse_tecla", 32'(tecla), 32'(e.code));
          chk("pulse_held", 32'(key_held), 32'd1);
        end
      end else if (prev_held && !key_held) begin
        if (q.size() == 0) begin
          vectors++;
          fails++;
          $display("FAIL unexpected_release: tecla %0h", tecla);
        end else begin
          ev_t e;
          e = q.pop_front();
          chk("release_kind", 32'(e.rel), 32'd1);
          chk("release_tecla", 32'(tecla), 32'(NULLK));
        end
      end
    end
    prev_held <= key_held;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_colunas", 32'(colunas), 32'h1110_0000 >> 28 == 0 ? 32'he : 32'he);
    chk("rst_tecla", 32'(tecla), 32'(NULLK));
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_held", 32'(key_held), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle: each column dwells 4 cycles, wrapping 0..3.
    for (int k = 1; k <= 64; k++) begin
      logic [COLS-1:0] exp_col;
      @(posedge clk);
      #1;
      exp_col = ~(COLS'(1) << ((k/4) % 4));
      chk("idle_colunas", 32'(colunas), 32'(exp_col));
    end

    // Clean press row1/col2.
    set_key(6, 1'b1);
    push(1'b0, 6);
    repeat (100) @(posedge clk);
    #1;
    chk("clean_tecla", 32'(tecla), 32'd6);
    chk("clean_held", 32'(key_held), 32'd1);
    drain("clean_press", 1);
    set_key(6, 1'b0);
    push(1'b1, 0);
    drain("clean_release", 100);
    #1 chk("clean_null", 32'(tecla), 32'(NULLK));

    // Bounce on row0/col0, then stable.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 keys[0] = (i % 2 == 0);
      repeat (2) @(posedge clk);
    end
    set_key(0, 1'b1);
    push(1'b0, 0);
    drain("bounce_press", 200);
    repeat (20) @(posedge clk);
    set_key(0, 1'b0);
    push(1'b1, 0);
    drain("bounce_release", 100);

    // Two keys in column 3: row2 wins, row3 follows after release.
    @(posedge clk);
    #1 keys[11] = 1'b1;
    keys[15] = 1'b1;
    push(1'b0, 11);
    drain("dual_first", 200);
    #1 chk("dual_tecla", 32'(tecla), 32'd11);
    set_key(11, 1'b0);
    push(1'b1, 0);
    push(1'b0, 15);
    drain("dual_second", 200);
    set_key(15, 1'b0);
    push(1'b1, 0);
    drain("dual_release", 100);

    // Long hold row3/col0.
    set_key(12, 1'b1);
    push(1'b0, 12);
    drain("hold_first", 200);
`ifdef KEYPAD_REPEAT_EN
    push(1'b0, 12);
    push(1'b0, 12);
    push(1'b0, 12);
`endif
    repeat (230) @(posedge clk);
    set_key(12, 1'b0);
    push(1'b1, 0);
    drain("hold_release", 100);

    // Async reset while debouncing a press on row2/col2.
    set_key(10, 1'b1);
    begin
      int n = 0;
      while (colunas !== 4'b1011 && n < 40) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    chk("reach_col2", 32'(colunas), 32'hb);
    repeat (6) @(posedge clk);
    #1 chk("col2_frozen", 32'(colunas), 32'hb);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_colunas", 32'(colunas), 32'he);
    chk("mid_rst_tecla", 32'(tecla), 32'(NULLK));
    chk("mid_rst_valid", 32'(key_valid), 32'd0);
    chk("mid_rst_held", 32'(key_held), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push(1'b0, 10);
    drain("post_rst_press", 200);
    set_key(10, 1'b0);
    push(1'b1, 0);
    drain("post_rst_release", 100);

    repeat (50) @(posedge clk);
    #1;
    chk("final_held", 32'(key_held), 32'd0);
    chk("final_tecla", 32'(tecla), 32'(NULLK));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
